// File: rtl/aes_sbox_stream_decipher.sv
// ----------------------------------------------------------------------------
// aes_sbox_stream_decipher
//
// Receive side of the AES S-box stream cipher. The block regenerates the
// keystream ks = sbox(key + n) mod 256 and XORs each ciphertext byte back to
// plaintext. Plaintext goes into a small first-word-fall-through FIFO, and a
// valid/accept handshake drains that FIFO to the consumer.
//
// The upstream source has no backpressure. When the FIFO is full, the
// decrypted byte is dropped and the sticky overflow flag is set. The keystream
// counter still advances, so later bytes decrypt correctly.
//
// Optional feature (macro AES_SBOX_DEC_RESYNC_EN):
//   Adds the 'resync' input. When resync=1 at an edge, the block returns to
//   waiting for a key, clears the counter, flushes the FIFO and clears
//   overflow. The block ignores resync during the post-reset init cycle.
//
// Parameters:
//   FIFO_DEPTH      plaintext FIFO entries; must be a power of 2 and >= 2
//
// Ports:
//   clk             clock, rising edge
//   rst_n           asynchronous reset, active low
//   din_valid       cipher_in_char holds a byte this cycle
//   simmetric_key   keystream seed, sampled with the first byte after (re)key
//   cipher_in_char  ciphertext byte
//   resync          (AES_SBOX_DEC_RESYNC_EN only) re-key and flush
//   dout_accept     consumer takes txt_out_char when dout_valid=1
//   txt_out_char    plaintext byte at the FIFO head
//   dout_valid      FIFO non-empty
//   fifo_full       FIFO holds FIFO_DEPTH bytes
//   overflow        sticky: a decrypted byte was dropped because the FIFO was full
// ----------------------------------------------------------------------------
module aes_sbox_stream_decipher #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din_valid,
    input  logic [7:0] simmetric_key,
    input  logic [7:0] cipher_in_char,
`ifdef AES_SBOX_DEC_RESYNC_EN
    input  logic       resync,
`endif
    input  logic       dout_accept,
    output logic [7:0] txt_out_char,
    output logic       dout_valid,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        StInit    = 2'd0,
        StWaitKey = 2'd1,
        StRun     = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      ctr_q, ctr_d;
    logic [7:0]      ks_idx;
    logic [7:0]      pt;
    logic            byte_in;     // a byte is consumed (keystream steps)
    logic            resync_act;  // flush/re-key this edge

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] rd_ptr_inc;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      head_q, head_d;
    logic            ovf_q, ovf_d;
    logic            do_push, do_pop, has_room;

`ifdef AES_SBOX_DEC_RESYNC_EN
    assign resync_act = resync && (state_q != StInit);
`else
    assign resync_act = 1'b0;
`endif

    // Keystream FSM
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        ks_idx  = ctr_q;
        byte_in = 1'b0;
        case (state_q)
            StInit: begin
                state_d = StWaitKey;
            end
            StWaitKey: begin
                if (din_valid) begin
                    ks_idx  = simmetric_key;
                    ctr_d   = simmetric_key + 8'd1;
                    state_d = StRun;
                    byte_in = 1'b1;
                end
            end
            StRun: begin
                if (din_valid) begin
                    ctr_d   = ctr_q + 8'd1;
                    byte_in = 1'b1;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
        // Resync discards any coincident byte without stepping the counter.
        if (resync_act) begin
            state_d = StWaitKey;
            ctr_d   = 8'h00;
            byte_in = 1'b0;
        end
    end

    assign pt = cipher_in_char ^ SBOX[ks_idx];

    // FIFO control
    assign dout_valid = (count_q != '0);
    assign fifo_full  = (count_q == CntFull);
    assign rd_ptr_inc = rd_ptr_q + PtrOne;

    always_comb begin
        do_pop   = dout_valid && dout_accept && !resync_act;
        // A pop in the same cycle frees a slot for the incoming byte.
        has_room = (count_q != CntFull) || do_pop;
        do_push  = byte_in && has_room;

        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q | (byte_in && !has_room);
        head_d   = head_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_inc;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntOne;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntOne;
        end

        // The head register tracks the entry at rd_ptr. It holds its last value
        // when the FIFO drains empty.
        if (do_push && ((count_q == '0) || (do_pop && count_q == CntOne))) begin
            head_d = pt;
        end else if (do_pop && count_q > CntOne) begin
            head_d = mem_q[rd_ptr_inc];
        end

        if (resync_act) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StInit;
            ctr_q    <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= 8'h00;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; it is only read through head_q once written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= pt;
        end
    end

    assign txt_out_char = head_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_aes_sbox_stream_decipher.sv
// ----------------------------------------------------------------------------
// tb_aes_sbox_stream_decipher
//
// Directed testbench for aes_sbox_stream_decipher. Each vector was computed by
// hand from the AES S-box.
//
// The bench drives inputs on the falling clock edge and samples outputs on the
// next falling edge, after the DUT's rising edge.
// ----------------------------------------------------------------------------
module tb_aes_sbox_stream_decipher;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] simmetric_key = 8'h00;
    logic [7:0] cipher_in_char = 8'h00;
    logic       resync = 1'b0;
    logic       dout_accept = 1'b0;
    logic [7:0] txt_out_char;
    logic       dout_valid;
    logic       fifo_full;
    logic       overflow;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    aes_sbox_stream_decipher #(
        .FIFO_DEPTH(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .din_valid      (din_valid),
        .simmetric_key  (simmetric_key),
        .cipher_in_char (cipher_in_char),
`ifdef AES_SBOX_DEC_RESYNC_EN
        .resync         (resync),
`endif
        .dout_accept    (dout_accept),
        .txt_out_char   (txt_out_char),
        .dout_valid     (dout_valid),
        .fifo_full      (fifo_full),
        .overflow       (overflow)
    );

    // Resets the DUT and returns once the DUT reaches the wait-for-key state.
    task automatic do_reset();
        rst_n       = 1'b0;
        din_valid   = 1'b0;
        dout_accept = 1'b0;
        resync      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (txt_out_char !== 8'h00) begin
            bad++; $display("FAIL reset_txt: got %02h want 00", txt_out_char);
        end
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b want 0", dout_valid);
        end
        total++;
        if (fifo_full !== 1'b0) begin
            bad++; $display("FAIL reset_full: got %b want 0", fifo_full);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL reset_ovf: got %b want 0", overflow);
        end
        // The DUT must ignore a byte presented during the init cycle.
        rst_n          = 1'b1;
        din_valid      = 1'b1;
        simmetric_key  = 8'h00;
        cipher_in_char = 8'haa;
        @(negedge clk);
        din_valid = 1'b0;
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL init_ignore_valid: got %b want 0", dout_valid);
        end
        // The key is still unsampled, so 63 with key 00 decrypts to 00.
        dout_accept    = 1'b1;
        din_valid      = 1'b1;
        cipher_in_char = 8'h63;
        @(negedge clk);
        din_valid = 1'b0;
        total++;
        if (txt_out_char !== 8'h00 || dout_valid !== 1'b1) begin
            bad++;
            $display("FAIL init_then_key: got %02h/%b want 00/1", txt_out_char, dout_valid);
        end
    endtask

    task automatic test_back_to_back_stream();
        logic [7:0] cin [3];
        cin = '{8'h63, 8'h7c, 8'h77};
        do_reset();
        dout_accept   = 1'b1;
        simmetric_key = 8'h00;
        for (int i = 0; i < 3; i++) begin
            din_valid      = 1'b1;
            cipher_in_char = cin[i];
            @(negedge clk);
            total++;
            if (txt_out_char !== 8'h00 || dout_valid !== 1'b1) begin
                bad++;
                $display("FAIL t1_byte%0d: got %02h/%b want 00/1", i, txt_out_char, dout_valid);
            end
        end
        din_valid = 1'b0;
        @(negedge clk);
        total++;
        if (dout_valid !== 1'b0 || txt_out_char !== 8'h00) begin
            bad++;
            $display("FAIL t1_drained: got %02h/%b want 00/0", txt_out_char, dout_valid);
        end
    endtask

    task automatic test_counter_wrap();
        logic [7:0] cin [3];
        logic [7:0] exp [3];
        cin = '{8'h57, 8'h22, 8'h7c};
        exp = '{8'h41, 8'h41, 8'h00};
        do_reset();
        dout_accept   = 1'b1;
        simmetric_key = 8'hff;
        for (int i = 0; i < 3; i++) begin
            din_valid      = 1'b1;
            cipher_in_char = cin[i];
            @(negedge clk);
            total++;
            if (txt_out_char !== exp[i]) begin
                bad++;
                $display("FAIL t2_byte%0d: got %02h want %02h", i, txt_out_char, exp[i]);
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_gap();
        do_reset();
        dout_accept    = 1'b1;
        simmetric_key  = 8'h00;
        din_valid      = 1'b1;
        cipher_in_char = 8'h63;
        @(negedge clk);
        din_valid = 1'b0;
        total++;
        if (txt_out_char !== 8'h00) begin
            bad++; $display("FAIL t3_first: got %02h want 00", txt_out_char);
        end
        repeat (3) @(negedge clk);
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL t3_gap_valid: got %b want 0", dout_valid);
        end
        din_valid      = 1'b1;
        cipher_in_char = 8'h7d;
        @(negedge clk);
        din_valid = 1'b0;
        total++;
        if (txt_out_char !== 8'h01 || dout_valid !== 1'b1) begin
            bad++;
            $display("FAIL t3_second: got %02h/%b want 01/1", txt_out_char, dout_valid);
        end
    endtask

    task automatic test_overflow();
        // Plaintext 10..15 encrypted with key 00 (sbox 63,7c,77,7b,f2,6b).
        logic [7:0] cin [6];
        logic [7:0] exp [4];
        cin = '{8'h73, 8'h6d, 8'h65, 8'h68, 8'he6, 8'h7e};
        exp = '{8'h10, 8'h11, 8'h12, 8'h13};
        do_reset();
        dout_accept   = 1'b0;
        simmetric_key = 8'h00;
        for (int i = 0; i < 6; i++) begin
            din_valid      = 1'b1;
            cipher_in_char = cin[i];
            @(negedge clk);
            if (i == 3) begin
                total++;
                if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
                    bad++;
                    $display("FAIL t4_full_at4: got full=%b ovf=%b want 1/0", fifo_full, overflow);
                end
            end
            if (i == 4) begin
                total++;
                if (overflow !== 1'b1) begin
                    bad++; $display("FAIL t4_ovf_at5: got %b want 1", overflow);
                end
            end
        end
        din_valid   = 1'b0;
        dout_accept = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (txt_out_char !== exp[k] || dout_valid !== 1'b1) begin
                bad++;
                $display("FAIL t4_drain%0d: got %02h/%b want %02h/1", k, txt_out_char,
                         dout_valid, exp[k]);
            end
            @(negedge clk);
        end
        total++;
        if (dout_valid !== 1'b0 || overflow !== 1'b1 || fifo_full !== 1'b0) begin
            bad++;
            $display("FAIL t4_empty: got valid=%b ovf=%b full=%b want 0/1/0", dout_valid,
                     overflow, fifo_full);
        end
        // Dropped bytes still advanced the counter to 06 (sbox 6f).
        din_valid      = 1'b1;
        cipher_in_char = 8'h30;
        @(negedge clk);
        din_valid = 1'b0;
        total++;
        if (txt_out_char !== 8'h5f || dout_valid !== 1'b1) begin
            bad++;
            $display("FAIL t4_sync: got %02h/%b want 5f/1", txt_out_char, dout_valid);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] cin [4];
        logic [7:0] exp [3];
        cin = '{8'h73, 8'h6d, 8'h65, 8'h68};
        exp = '{8'h12, 8'h13, 8'h20};
        do_reset();
        dout_accept   = 1'b0;
        simmetric_key = 8'h00;
        for (int i = 0; i < 4; i++) begin
            din_valid      = 1'b1;
            cipher_in_char = cin[i];
            @(negedge clk);
        end
        total++;
        if (fifo_full !== 1'b1) begin
            bad++; $display("FAIL t5_full: got %b want 1", fifo_full);
        end
        // Counter 04 -> sbox f2; plaintext 20.
        cipher_in_char = 8'hd2;
        dout_accept    = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        total++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0 || txt_out_char !== 8'h11) begin
            bad++;
            $display("FAIL t5_pushpop: got full=%b ovf=%b txt=%02h want 1/0/11", fifo_full,
                     overflow, txt_out_char);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (txt_out_char !== exp[k]) begin
                bad++;
                $display("FAIL t5_drain%0d: got %02h want %02h", k, txt_out_char, exp[k]);
            end
        end
        @(negedge clk);
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL t5_empty: got %b want 0", dout_valid);
        end
    endtask

`ifdef AES_SBOX_DEC_RESYNC_EN
    task automatic test_resync();
        logic [7:0] cin [5];
        cin = '{8'h73, 8'h6d, 8'h65, 8'h68, 8'he6};
        do_reset();
        dout_accept   = 1'b0;
        simmetric_key = 8'h00;
        for (int i = 0; i < 5; i++) begin
            din_valid      = 1'b1;
            cipher_in_char = cin[i];
            @(negedge clk);
        end
        total++;
        if (overflow !== 1'b1) begin
            bad++; $display("FAIL t6_pre_ovf: got %b want 1", overflow);
        end
        resync         = 1'b1;
        din_valid      = 1'b1;
        dout_accept    = 1'b1;
        cipher_in_char = 8'h55;
        @(negedge clk);
        resync    = 1'b0;
        din_valid = 1'b0;
        total++;
        if (dout_valid !== 1'b0 || overflow !== 1'b0 || fifo_full !== 1'b0) begin
            bad++;
            $display("FAIL t6_flush: got valid=%b ovf=%b full=%b want 0/0/0", dout_valid,
                     overflow, fifo_full);
        end
        simmetric_key  = 8'h01;
        din_valid      = 1'b1;
        cipher_in_char = 8'h7c;
        @(negedge clk);
        din_valid = 1'b0;
        total++;
        if (txt_out_char !== 8'h00 || dout_valid !== 1'b1) begin
            bad++;
            $display("FAIL t6_rekey: got %02h/%b want 00/1", txt_out_char, dout_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back_stream();
        test_counter_wrap();
        test_gap();
        test_overflow();
        test_full_push_pop();
`ifdef AES_SBOX_DEC_RESYNC_EN
        test_resync();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
